// File: rtl/rtc_cal_pkg.sv
// rtl/rtc_cal_pkg.sv - shared FSM states, time constants and month-length helpers for rtc_calendar
// RTC_CALENDAR_BCD_EN adds the BCD state and the shift-add-3 step function.
package rtc_cal_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DDAY,
        ST_DHR,
        ST_DMIN,
        ST_DWK,
        ST_YEAR,
        ST_MONTH,
`ifdef RTC_CALENDAR_BCD_EN
        ST_BCD,
`endif
        ST_DONE
    } cal_state_t;

    localparam logic [31:0] SEC_PER_DAY   = 32'd86400;
    localparam logic [31:0] SEC_PER_HOUR  = 32'd3600;
    localparam logic [31:0] SEC_PER_MIN   = 32'd60;
    localparam logic [31:0] DAYS_PER_WEEK = 32'd7;

    function automatic logic [4:0] month_days(input logic [7:0] month);
        case (month)
            8'd2:                      return 5'd28;
            8'd4, 8'd6, 8'd9, 8'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    function automatic logic [4:0] month_len(input logic [7:0] month, input logic leap);
        return month_days(month) + {4'd0, (leap && (month == 8'd2))};
    endfunction

`ifdef RTC_CALENDAR_BCD_EN
    // One double-dabble step on {bcd[15:0], bin[11:0]}: add 3 to digits >= 5, then shift.
    function automatic logic [27:0] dd_step(input logic [27:0] sr);
        logic [27:0] t;
        t = sr;
        for (int i = 0; i < 4; i++) begin
            if (t[12 + 4*i +: 4] >= 4'd5)
                t[12 + 4*i +: 4] = t[12 + 4*i +: 4] + 4'd3;
        end
        return {t[26:0], 1'b0};
    endfunction
`endif

endpackage

// File: rtl/rtc_cal_div.sv
// rtl/rtc_cal_div.sv - sequential 32/32 restoring divider, one start cycle plus 32 iterations
// Result ports carry only the bits the calendar needs: quotients fit 16 bits, remainders 17 bits.
module rtc_cal_div (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] quotient_o,
    output logic [16:0] remainder_o
);
    logic [31:0] quo_q, rem_q, quo_n, rem_n;
    logic [5:0]  cnt_q;
    logic        busy_q;
    logic [32:0] rem_sh, diff;

    // Results are the combinational outcome of the final iteration, valid while done_o is high.
    always_comb begin
        rem_sh = {rem_q, quo_q[31]};
        diff   = rem_sh - {1'b0, divisor_i};
        if (diff[32]) begin
            rem_n = rem_sh[31:0];
            quo_n = {quo_q[30:0], 1'b0};
        end else begin
            rem_n = diff[31:0];
            quo_n = {quo_q[30:0], 1'b1};
        end
        busy_o      = busy_q;
        done_o      = busy_q && (cnt_q == 6'd1);
        quotient_o  = quo_n[15:0];
        remainder_o = rem_n[16:0];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            quo_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i && !busy_q) begin
            quo_q  <= dividend_i;
            rem_q  <= '0;
            cnt_q  <= 6'd32;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            quo_q <= quo_n;
            rem_q <= rem_n;
            cnt_q <= cnt_q - 6'd1;
            if (cnt_q == 6'd1)
                busy_q <= 1'b0;
        end
    end
endmodule

// File: rtl/rtc_calendar.sv
// rtl/rtc_calendar.sv - iterative epoch-seconds to calendar converter with valid/ready handshakes
// RTC_CALENDAR_BCD_EN selects packed-BCD field outputs (wday stays binary).
module rtc_calendar
    import rtc_cal_pkg::*;
#(
    parameter int BASE_YEAR = 1970,
    parameter int BASE_WDAY = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [7:0]           sec_o,
    output logic [7:0]           min_o,
    output logic [7:0]           hour_o,
    output logic [7:0]           day_o,
    output logic [7:0]           month_o,
    output logic [15:0]          year_o,
    output logic [2:0]           wday_o,
    output logic                 busy_o
);
    localparam logic [1:0] Y4_INIT   = 2'(BASE_YEAR % 4);
    localparam logic [6:0] Y100_INIT = 7'(BASE_YEAR % 100);
    localparam logic [8:0] Y400_INIT = 9'(BASE_YEAR % 400);
    localparam logic [2:0] WDAY_BASE = 3'(BASE_WDAY);

    cal_state_t  state_q, state_d;
    logic [31:0] cnt_q;
    logic [15:0] days_q, year_q;
    logic [16:0] rem_q;
    logic [7:0]  sec_q, min_q, hour_q, day_q, month_q;
    logic [2:0]  wday_q, wday_n;
    logic [1:0]  y4_q;
    logic [6:0]  y100_q;
    logic [8:0]  y400_q;
    logic        leap, year_step, month_step, div_state;
    logic [8:0]  ylen;
    logic [4:0]  mlen;
    logic [3:0]  wsum, wsum_adj;
    logic [31:0] div_dividend, div_divisor;
    logic        div_busy, div_done;
    logic [15:0] div_quo;
    logic [16:0] div_rem;
`ifdef RTC_CALENDAR_BCD_EN
    logic [27:0] bcd_sr_q [6];
    logic [27:0] bcd_nxt [6];
    logic [3:0]  bcd_cnt_q;
`endif

    rtc_cal_div u_div (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (div_state && !div_busy),
        .dividend_i  (div_dividend),
        .divisor_i   (div_divisor),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    always_comb begin
        leap       = (y4_q == 2'd0) && ((y100_q != 7'd0) || (y400_q == 9'd0));
        ylen       = leap ? 9'd366 : 9'd365;
        mlen       = month_len(month_q, leap);
        year_step  = days_q >= {7'd0, ylen};
        month_step = days_q >= {11'd0, mlen};
        wsum       = {1'b0, div_rem[2:0]} + {1'b0, WDAY_BASE};
        wsum_adj   = wsum - 4'd7;
        wday_n     = (wsum >= 4'd7) ? wsum_adj[2:0] : wsum[2:0];
        div_state  = 1'b1;
        div_divisor  = SEC_PER_DAY;
        div_dividend = cnt_q;
        case (state_q)
            ST_DDAY: ;
            ST_DHR:  begin div_divisor = SEC_PER_HOUR;  div_dividend = {15'd0, rem_q};  end
            ST_DMIN: begin div_divisor = SEC_PER_MIN;   div_dividend = {15'd0, rem_q};  end
            ST_DWK:  begin div_divisor = DAYS_PER_WEEK; div_dividend = {16'd0, days_q}; end
            default: div_state = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid_i) state_d = ST_DDAY;
            ST_DDAY:  if (div_done) state_d = ST_DHR;
            ST_DHR:   if (div_done) state_d = ST_DMIN;
            ST_DMIN:  if (div_done) state_d = ST_DWK;
            ST_DWK:   if (div_done) state_d = ST_YEAR;
            ST_YEAR:  if (!year_step) state_d = ST_MONTH;
`ifdef RTC_CALENDAR_BCD_EN
            ST_MONTH: if (!month_step) state_d = ST_BCD;
            ST_BCD:   if (bcd_cnt_q == 4'd11) state_d = ST_DONE;
`else
            ST_MONTH: if (!month_step) state_d = ST_DONE;
`endif
            ST_DONE:  if (res_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == ST_IDLE);
        res_valid_o = (state_q == ST_DONE);
        busy_o      = (state_q != ST_IDLE);
        sec_o   = sec_q;
        min_o   = min_q;
        hour_o  = hour_q;
        day_o   = day_q;
        month_o = month_q;
        year_o  = year_q;
        wday_o  = wday_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q   <= '0;
            days_q  <= '0;
            rem_q   <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            day_q   <= '0;
            month_q <= '0;
            year_q  <= '0;
            wday_q  <= '0;
            y4_q    <= '0;
            y100_q  <= '0;
            y400_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (req_valid_i) begin
                    cnt_q   <= 32'(cnt_i);
                    year_q  <= 16'(BASE_YEAR);
                    month_q <= 8'd1;
                    y4_q    <= Y4_INIT;
                    y100_q  <= Y100_INIT;
                    y400_q  <= Y400_INIT;
                end
                ST_DDAY: if (div_done) begin
                    days_q <= div_quo;
                    rem_q  <= div_rem;
                end
                ST_DHR: if (div_done) begin
                    hour_q <= {3'd0, div_quo[4:0]};
                    rem_q  <= div_rem;
                end
                ST_DMIN: if (div_done) begin
                    min_q <= {2'd0, div_quo[5:0]};
                    sec_q <= {2'd0, div_rem[5:0]};
                end
                ST_DWK: if (div_done) wday_q <= wday_n;
                ST_YEAR: if (year_step) begin
                    days_q <= days_q - {7'd0, ylen};
                    year_q <= year_q + 16'd1;
                    y4_q   <= y4_q + 2'd1;
                    y100_q <= (y100_q == 7'd99)  ? 7'd0 : y100_q + 7'd1;
                    y400_q <= (y400_q == 9'd399) ? 9'd0 : y400_q + 9'd1;
                end
                ST_MONTH: begin
                    if (month_step) begin
                        days_q  <= days_q - {11'd0, mlen};
                        month_q <= month_q + 8'd1;
                    end else begin
                        day_q <= {3'd0, days_q[4:0] + 5'd1};
                    end
                end
`ifdef RTC_CALENDAR_BCD_EN
                ST_BCD: if (bcd_cnt_q == 4'd11) begin
                    sec_q   <= bcd_nxt[0][19:12];
                    min_q   <= bcd_nxt[1][19:12];
                    hour_q  <= bcd_nxt[2][19:12];
                    day_q   <= bcd_nxt[3][19:12];
                    month_q <= bcd_nxt[4][19:12];
                    year_q  <= bcd_nxt[5][27:12];
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef RTC_CALENDAR_BCD_EN
    always_comb begin
        for (int i = 0; i < 6; i++)
            bcd_nxt[i] = dd_step(bcd_sr_q[i]);
    end

    // Day is loaded from days_q+1 since day_q is written on the same edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 6; i++) bcd_sr_q[i] <= '0;
            bcd_cnt_q <= '0;
        end else if (state_q == ST_MONTH && !month_step) begin
            bcd_sr_q[0] <= {20'd0, sec_q};
            bcd_sr_q[1] <= {20'd0, min_q};
            bcd_sr_q[2] <= {20'd0, hour_q};
            bcd_sr_q[3] <= {23'd0, days_q[4:0] + 5'd1};
            bcd_sr_q[4] <= {20'd0, month_q};
            bcd_sr_q[5] <= {16'd0, year_q[11:0]};
            bcd_cnt_q   <= '0;
        end else if (state_q == ST_BCD) begin
            for (int i = 0; i < 6; i++) bcd_sr_q[i] <= bcd_nxt[i];
            bcd_cnt_q <= bcd_cnt_q + 4'd1;
        end
    end
`endif
endmodule
